// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the A/B symbol pulse transmitter.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SYM_A       = 1'b1;
    localparam logic SYM_B       = 1'b0;
    localparam int   SEQ_MAX_LEN = 8;

endpackage

// File: rtl/seq_tx_timer.sv
// Loadable down-counter that holds at zero; the zero flag comes straight off the count flop.
module seq_tx_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_pulse_tx.sv
// Serialises a shadowed symbol pattern into mutually exclusive A/B pulses,
// each pulse followed by an idle gap, with start/busy/done handshake and abort.
module seq_pulse_tx
    import seq_tx_pkg::*;
#(
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 2,
    parameter int MAX_LEN   = SEQ_MAX_LEN
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_start,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [3:0]         i_len,
    input  logic               i_abort,
    output logic               o_a_out,
    output logic               o_b_out,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CW = $clog2(((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC) + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      r_last;
    logic               r_a;
    logic               r_b;
    logic               r_busy;
    logic               r_done;

    logic [3:0]    w_len_sat;
    logic [IW-1:0] w_last;
    logic [IW-1:0] w_nidx;
    logic          w_nsym;
    logic          w_zero;
    logic          w_load;
    logic [CW-1:0] w_load_val;

    assign w_len_sat = (32'(i_len) > MAX_LEN) ? 4'(MAX_LEN) : i_len;
    assign w_last    = IW'(w_len_sat - 4'd1);
    assign w_nidx    = r_idx + 1'b1;
    assign w_nsym    = r_pat[w_nidx];

    // Timer reloads exactly on the edges where the FSM enters PULSE or GAP.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = PULSE_LD;
        case (r_state)
            IDLE:  if (i_start && w_len_sat != 4'd0) w_load = 1'b1;
            PULSE: if (w_zero) begin
                       w_load     = 1'b1;
                       w_load_val = GAP_LD;
                   end
            GAP:   if (w_zero && r_idx != r_last) w_load = 1'b1;
            default: ;
        endcase
    end

    seq_tx_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_abort && r_state != IDLE) begin
            r_state <= IDLE;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pat  <= i_pattern;
                        r_last <= w_last;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (w_len_sat != 4'd0) begin
                            r_state <= PULSE;
                            r_a     <= (i_pattern[0] == SYM_A);
                            r_b     <= (i_pattern[0] == SYM_B);
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (w_zero) begin
                        r_state <= GAP;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                    end
                end
                GAP: begin
                    if (w_zero) begin
                        if (r_idx == r_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= PULSE;
                            r_idx   <= w_nidx;
                            r_a     <= (w_nsym == SYM_A);
                            r_b     <= (w_nsym == SYM_B);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_a_out = r_a;
    assign o_b_out = r_b;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_seq_pulse_tx.sv
// Directed bench: cycle-by-cycle vector table for the short-pulse build, hand sequences
// for async reset and the saturated-length, wide-pulse build.
module tb_seq_pulse_tx;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len    = 4'd0;

    logic a1, b1, busy1, done1;
    logic a2, b2, busy2, done2;

    always #5 clk = ~clk;

    seq_pulse_tx #(.PULSE_CYC(1), .GAP_CYC(2), .MAX_LEN(8)) dut1 (
        .clk(clk), .resetn(resetn), .i_start(start), .i_pattern(pattern), .i_len(len),
        .i_abort(abort), .o_a_out(a1), .o_b_out(b1), .o_busy(busy1), .o_done(done1)
    );

    seq_pulse_tx #(.PULSE_CYC(3), .GAP_CYC(1), .MAX_LEN(8)) dut2 (
        .clk(clk), .resetn(resetn), .i_start(start), .i_pattern(pattern), .i_len(len),
        .i_abort(abort), .o_a_out(a2), .o_b_out(b2), .o_busy(busy2), .o_done(done2)
    );

    // exp is {a_out, b_out, busy, done} for the cycle after the inputs are applied
    typedef struct {
        logic       start;
        logic [7:0] pat;
        logic [3:0] len;
        logic       abort;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] burst1[13];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b ({a,b,busy,done})", name, act, exp);
        end
    endtask

    function automatic void push(logic s, logic [7:0] p, logic [3:0] l, logic ab, logic [3:0] e);
        vec_t v;
        v.start = s; v.pat = p; v.len = l; v.abort = ab; v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        int a_cnt;
        int b_cnt;
        logic [3:0] e;

        // pattern 0B, len 4, P=1 G=2: A in cycle 1, A in 4, B in 7, A in 10, done in 13
        burst1 = '{4'b1010, 4'b0010, 4'b0010, 4'b1010, 4'b0010, 4'b0010, 4'b0110,
                   4'b0010, 4'b0010, 4'b1010, 4'b0010, 4'b0010, 4'b0011};

        // basic burst, then idle
        push(1, 8'h0B, 4'd4, 0, burst1[0]);
        for (int c = 1; c < 13; c++) push(0, 8'h0B, 4'd4, 0, burst1[c]);
        push(0, 8'h00, 4'd0, 0, 4'b0000);
        // start held and pattern/len changed during the burst, including the DONE cycle
        push(1, 8'h0B, 4'd4, 0, burst1[0]);
        for (int c = 1; c < 13; c++) push(1, 8'hFF, 4'd8, 0, burst1[c]);
        push(1, 8'hFF, 4'd8, 0, 4'b0000);
        push(0, 8'hFF, 4'd8, 0, 4'b0000);
        // len = 0: one-cycle busy+done, no pulses
        push(1, 8'hFF, 4'd0, 0, 4'b0011);
        push(0, 8'hFF, 4'd0, 0, 4'b0000);
        // abort in GAP (cycle 5), restart in cycle 7, full burst follows
        push(1, 8'h0B, 4'd4, 0, burst1[0]);
        for (int c = 1; c < 5; c++) push(0, 8'h0B, 4'd4, 0, burst1[c]);
        push(0, 8'h0B, 4'd4, 1, 4'b0000);
        push(0, 8'h0B, 4'd4, 0, 4'b0000);
        push(1, 8'h0B, 4'd4, 0, burst1[0]);
        for (int c = 1; c < 13; c++) push(0, 8'h0B, 4'd4, 0, burst1[c]);
        push(0, 8'h0B, 4'd4, 0, 4'b0000);
        // abort alongside start in IDLE is ignored; abort in PULSE cancels
        push(1, 8'h0B, 4'd4, 1, burst1[0]);
        push(0, 8'h0B, 4'd4, 1, 4'b0000);
        push(0, 8'h0B, 4'd4, 0, 4'b0000);
        // B first symbol, single-symbol burst
        push(1, 8'h0A, 4'd1, 0, 4'b0110);
        push(0, 8'h0A, 4'd1, 0, 4'b0010);
        push(0, 8'h0A, 4'd1, 0, 4'b0010);
        push(0, 8'h0A, 4'd1, 0, 4'b0011);
        push(0, 8'h0A, 4'd1, 0, 4'b0000);

        #2;
        chk("reset_dut1", {a1, b1, busy1, done1}, 4'b0000);
        chk("reset_dut2", {a2, b2, busy2, done2}, 4'b0000);
        #10 resetn = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            start = tbl[i].start; pattern = tbl[i].pat; len = tbl[i].len; abort = tbl[i].abort;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), {a1, b1, busy1, done1}, tbl[i].exp);
        end
        start = 1'b0; abort = 1'b0;

        // async reset in the middle of a 3-cycle pulse
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1; pattern = 8'h0B; len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        chk("pre_reset_pulse", {a2, b2, busy2, done2}, 4'b1010);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_dut2", {a2, b2, busy2, done2}, 4'b0000);
        chk("async_reset_dut1", {a1, b1, busy1, done1}, 4'b0000);
        #2 resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_reset_idle%0d", c), {a1, b1, busy1, done1} | {a2, b2, busy2, done2}, 4'b0000);
        end

        // len 15 saturates to 8; pattern AA gives B,A,B,A,... each 3 cycles, done at 33
        start = 1'b1; pattern = 8'hAA; len = 4'd15;
        a_cnt = 0; b_cnt = 0;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c <= 32) begin
                if ((c - 1) % 4 < 3)
                    e = (((c - 1) / 4) % 2 == 1) ? 4'b1010 : 4'b0110;
                else
                    e = 4'b0010;
            end else if (c == 33) begin
                e = 4'b0011;
            end else begin
                e = 4'b0000;
            end
            if (a2) a_cnt++;
            if (b2) b_cnt++;
            chk($sformatf("sat_c%0d", c), {a2, b2, busy2, done2}, e);
        end
        chk("sat_a_cycles", 4'(a_cnt), 4'd12);
        chk("sat_b_cycles", 4'(b_cnt), 4'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
